// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and requester ids for the memory port arbiter
package arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_LSU   = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way round-robin pick
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic       any,
  output logic       winner
);

  // On a tie the side that was not served last wins; otherwise the lone requester wins.
  always_comb begin
    any = |valid;
    if (&valid) winner = ~last;
    else        winner = valid[1];
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin sharing of one memory port between fetch and LSU
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int P_WIDTH  = 32,
  parameter int P_ADDR_W = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_req0_valid,
  input  logic [P_ADDR_W-1:0] i_req0_addr,
  input  logic                i_req1_valid,
  input  logic [P_ADDR_W-1:0] i_req1_addr,
  input  logic                i_req1_we,
  input  logic [P_WIDTH-1:0]  i_req1_wdata,
  output logic                o_req0_ready,
  output logic                o_req1_ready,
  output logic [P_WIDTH-1:0]  o_rdata,
  output logic                o_mem_valid,
  output logic [P_ADDR_W-1:0] o_mem_addr,
  output logic                o_mem_we,
  output logic [P_WIDTH-1:0]  o_mem_wdata,
  input  logic                i_mem_ready,
  input  logic [P_WIDTH-1:0]  i_mem_rdata,
  output logic                o_sel,
  output logic                o_busy
);

  arb_state_e state_q, state_d;
  logic       sel_q, sel_d;
  logic       last_q, last_d;
  logic       pick_any, pick_winner;

  rr_pick2 u_pick (
    .valid  ({i_req1_valid, i_req0_valid}),
    .last   (last_q),
    .any    (pick_any),
    .winner (pick_winner)
  );

  // last_q resets to the LSU so the first tie after reset goes to fetch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ARB_IDLE;
      sel_q   <= REQ_FETCH;
      last_q  <= REQ_LSU;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_d       = last_q;
    o_mem_valid  = 1'b0;
    o_busy       = 1'b0;
    o_sel        = REQ_FETCH;
    o_req0_ready = 1'b0;
    o_req1_ready = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          sel_d   = pick_winner;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        o_mem_valid = 1'b1;
        o_busy      = 1'b1;
        o_sel       = sel_q;
        if (i_mem_ready) begin
          o_req0_ready = (sel_q == REQ_FETCH);
          o_req1_ready = (sel_q == REQ_LSU);
          last_d       = sel_q;
          state_d      = ARB_IDLE;
        end
      end
    endcase
  end

  // Fetch never writes, so its side of the write path is tied to zero.
  assign o_mem_addr  = (o_sel == REQ_LSU) ? i_req1_addr : i_req0_addr;
  assign o_mem_we    = o_mem_valid && (o_sel == REQ_LSU) && i_req1_we;
  assign o_mem_wdata = (o_sel == REQ_LSU) ? i_req1_wdata : '0;
  assign o_rdata     = i_mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized checks of mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int W  = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          v0, v1, we1, mem_ready;
  logic [AW-1:0] a0, a1;
  logic [W-1:0]  wd1, mem_rdata;
  logic          ready0, ready1, mem_valid, mem_we, sel, busy;
  logic [W-1:0]  rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.P_WIDTH(W), .P_ADDR_W(AW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req0_valid (v0),
    .i_req0_addr  (a0),
    .i_req1_valid (v1),
    .i_req1_addr  (a1),
    .i_req1_we    (we1),
    .i_req1_wdata (wd1),
    .o_req0_ready (ready0),
    .o_req1_ready (ready1),
    .o_rdata      (rdata),
    .o_mem_valid  (mem_valid),
    .o_mem_addr   (mem_addr),
    .o_mem_we     (mem_we),
    .o_mem_wdata  (mem_wdata),
    .i_mem_ready  (mem_ready),
    .i_mem_rdata  (mem_rdata),
    .o_sel        (sel),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Behavioural model: one transaction at a time, ties alternate away from the last winner.
  bit          m_busy, m_sel, m_last, p0, p1;
  int          pulses;
  logic [AW-1:0] exp_addr;

  initial begin
    rst_n = 1'b0; v0 = 0; v1 = 0; we1 = 0; mem_ready = 0;
    a0 = '0; a1 = '0; wd1 = '0; mem_rdata = '0;
    step(); step();
    settle();
    chk("rst_mem_valid", mem_valid, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_ready0", ready0, 1'b0);
    chk("rst_ready1", ready1, 1'b0);
    chk("rst_sel", sel, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;

    // Single fetch, zero-wait memory
    step();
    v0 = 1; a0 = 32'h100;
    settle();
    chk("t1_idle_valid", mem_valid, 1'b0);
    step();
    mem_ready = 1; mem_rdata = 32'hDEADBEEF;
    settle();
    chk("t1_valid", mem_valid, 1'b1);
    chk("t1_addr", mem_addr, 32'h100);
    chk("t1_we", mem_we, 1'b0);
    chk("t1_sel", sel, 1'b0);
    chk("t1_ready0", ready0, 1'b1);
    chk("t1_ready1", ready1, 1'b0);
    chk("t1_rdata", rdata, 32'hDEADBEEF);
    step();
    v0 = 0; mem_ready = 0;
    settle();
    chk("t1_back_idle", mem_valid, 1'b0);
    chk("t1_no_pulse", ready0, 1'b0);

    // Tie right after reset: fetch first, then LSU write
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    v0 = 1; a0 = 32'h104; v1 = 1; a1 = 32'h200; we1 = 1; wd1 = 32'h55;
    step();
    settle();
    chk("t2_first_sel", sel, 1'b0);
    chk("t2_first_addr", mem_addr, 32'h104);
    chk("t2_first_we", mem_we, 1'b0);
    chk("t2_first_wdata", mem_wdata, 32'h0);
    mem_ready = 1;
    settle();
    chk("t2_ready0", ready0, 1'b1);
    step();
    v0 = 0; mem_ready = 0;
    settle();
    chk("t2_gap_idle", mem_valid, 1'b0);
    step();
    settle();
    chk("t2_second_sel", sel, 1'b1);
    chk("t2_second_addr", mem_addr, 32'h200);
    chk("t2_second_we", mem_we, 1'b1);
    chk("t2_second_wdata", mem_wdata, 32'h55);
    mem_ready = 1;
    settle();
    chk("t2_ready1", ready1, 1'b1);
    chk("t2_not_ready0", ready0, 1'b0);
    step();
    v1 = 0; we1 = 0; mem_ready = 0;

    // Both held valid, memory answers whenever the port is valid
    v0 = 1; a0 = 32'h300; v1 = 1; a1 = 32'h400;
    pulses = 0;
    m_sel = 1'b1;
    for (int c = 0; c < 16; c++) begin
      mem_ready = mem_valid;
      settle();
      chk("t3_valid_phase", mem_valid, (c % 2 == 1));
      if (mem_valid) begin
        m_sel = ~m_sel;
        chk("t3_sel", sel, m_sel);
      end
      if (ready0 || ready1) pulses++;
      step();
    end
    chk("t3_pulse_count", pulses, 8);
    v0 = 0; v1 = 0; mem_ready = 0;
    step();

    // Stalled fetch while LSU raises its request
    v0 = 1; a0 = 32'h500;
    step();
    v1 = 1; a1 = 32'h600; we1 = 0; wd1 = 32'h77;
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("t4_stall_valid", mem_valid, 1'b1);
      chk("t4_stall_addr", mem_addr, 32'h500);
      chk("t4_stall_we", mem_we, 1'b0);
      chk("t4_stall_sel", sel, 1'b0);
      chk("t4_stall_ready", {ready1, ready0}, 2'b00);
      step();
    end
    mem_ready = 1;
    settle();
    chk("t4_ready0", ready0, 1'b1);
    step();
    v0 = 0; mem_ready = 0;
    step();
    settle();
    chk("t4_lsu_sel", sel, 1'b1);
    chk("t4_lsu_addr", mem_addr, 32'h600);
    mem_ready = 1;
    settle();
    chk("t4_ready1", ready1, 1'b1);
    step();
    v1 = 0; mem_ready = 0;

    // Asynchronous reset in the middle of a transaction
    v0 = 1; a0 = 32'h700;
    step();
    settle();
    chk("t5_busy_before", mem_valid, 1'b1);
    rst_n = 1'b0;
    settle();
    chk("t5_valid_dropped", mem_valid, 1'b0);
    chk("t5_busy_dropped", busy, 1'b0);
    step();
    rst_n = 1'b1;
    v1 = 1; a1 = 32'h710;
    settle();
    chk("t5_idle_after", mem_valid, 1'b0);
    step();
    settle();
    chk("t5_tie_sel", sel, 1'b0);
    chk("t5_tie_addr", mem_addr, 32'h700);
    mem_ready = 1;
    step();
    v0 = 0; v1 = 0; mem_ready = 0;
    step();

    // Stray memory ready while idle
    mem_ready = 1;
    settle();
    chk("t6_no_ready", {ready1, ready0}, 2'b00);
    chk("t6_no_valid", mem_valid, 1'b0);
    step();
    mem_ready = 0;
    settle();
    chk("t6_still_idle", busy, 1'b0);

    // Randomized traffic against the model, from a fresh reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    m_busy = 0; m_sel = 0; m_last = 1; p0 = 0; p1 = 0;
    for (int c = 0; c < 400; c++) begin
      if (!p0 && $urandom_range(2) == 0) begin
        p0 = 1; a0 = $urandom;
      end
      if (!p1 && $urandom_range(2) == 0) begin
        p1 = 1; a1 = $urandom; we1 = $urandom_range(1); wd1 = $urandom;
      end
      v0 = p0; v1 = p1;
      mem_ready = m_busy ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
      mem_rdata = $urandom;
      settle();
      chk("rnd_valid", mem_valid, m_busy);
      chk("rnd_busy", busy, m_busy);
      chk("rnd_ready0", ready0, m_busy && mem_ready && !m_sel);
      chk("rnd_ready1", ready1, m_busy && mem_ready && m_sel);
      chk("rnd_rdata", rdata, mem_rdata);
      if (m_busy) begin
        exp_addr = m_sel ? a1 : a0;
        chk("rnd_sel", sel, m_sel);
        chk("rnd_addr", mem_addr, exp_addr);
        chk("rnd_we", mem_we, m_sel && we1);
        chk("rnd_wdata", mem_wdata, m_sel ? wd1 : 32'h0);
      end
      if (m_busy && mem_ready) begin
        if (m_sel) p1 = 0;
        else       p0 = 0;
        m_last = m_sel;
        m_busy = 0;
      end else if (!m_busy && (p0 || p1)) begin
        m_sel  = (p0 && p1) ? !m_last : p1;
        m_busy = 1;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
